// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds width defaults, the read-latency ceiling, the read tag and port indices.
package mem_arb_pkg;

    localparam int ADDR_W_DFLT = 16;
    localparam int DATA_W_DFLT = 16;
    localparam int RD_LAT_MAX  = 4;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-input grant picker; combinational, zero latency, no backpressure of its own.
// Round-robin on contention when MEM_ARB_RR_EN is defined, else port 0 has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt0,
    output logic gnt1
);

`ifdef MEM_ARB_RR_EN
    // On contention the port that did not win last time goes first.
    assign gnt0 = req0 && (!req1 || (last_gnt == PORT_LS));
`else
    logic unused_last;
    assign unused_last = last_gnt;
    assign gnt0        = req0;
`endif
    assign gnt1 = req1 && !gnt0;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory between two requesters; grant is same-cycle, read data RD_LAT cycles later.
// Losers hold req until granted; MEM_ARB_RR_EN selects round-robin instead of fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

    // An out-of-range latency references a module that does not exist, stopping elaboration.
    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        mem_arbiter_illegal_rd_lat u_bad ();
    end

    logic    pick0;
    logic    pick1;
    logic    last_gnt;
    logic    granted;
    logic    winner;
    rd_tag_t tag_q [RD_LAT];

    mem_arb_pick u_pick (
        .req0     (m0_req),
        .req1     (m1_req),
        .last_gnt (last_gnt),
        .gnt0     (pick0),
        .gnt1     (pick1)
    );

    // Grants are suppressed while reset is held so nothing reaches the memory.
    assign m0_gnt  = pick0 && rst_n;
    assign m1_gnt  = pick1 && rst_n;
    assign granted = m0_gnt || m1_gnt;
    assign winner  = m1_gnt ? PORT_LS : PORT_IF;

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        if (m0_gnt) begin
            mem_we   = m0_we;
            mem_addr = m0_addr;
            mem_data = m0_wdata;
        end else if (m1_gnt) begin
            mem_we   = m1_we;
            mem_addr = m1_addr;
            mem_data = m1_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= PORT_LS;
        end else if (granted) begin
            last_gnt <= winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: granted && !mem_we, port: winner};
            for (int i = 1; i < RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign m0_rvalid = tag_q[RD_LAT-1].valid && (tag_q[RD_LAT-1].port == PORT_IF);
    assign m1_rvalid = tag_q[RD_LAT-1].valid && (tag_q[RD_LAT-1].port == PORT_LS);
    assign m0_rdata  = mem_q;
    assign m1_rdata  = mem_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance at read latency 1 and one at latency 3 share all requester inputs.
// Expected grants, memory drive and read returns come from a transaction-level model with a shadow memory.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic        m0_gnt_a, m1_gnt_a, m0_rvalid_a, m1_rvalid_a, mem_we_a;
    logic [15:0] m0_rdata_a, m1_rdata_a, mem_addr_a, mem_data_a, mem_q_a;
    logic        m0_gnt_b, m1_gnt_b, m0_rvalid_b, m1_rvalid_b, mem_we_b;
    logic [15:0] m0_rdata_b, m1_rdata_b, mem_addr_b, mem_data_b, mem_q_b;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt_a), .m1_gnt(m1_gnt_a), .m0_rvalid(m0_rvalid_a), .m1_rvalid(m1_rvalid_a),
        .m0_rdata(m0_rdata_a), .m1_rdata(m1_rdata_a),
        .mem_addr(mem_addr_a), .mem_data(mem_data_a), .mem_we(mem_we_a), .mem_q(mem_q_a)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt_b), .m1_gnt(m1_gnt_b), .m0_rvalid(m0_rvalid_b), .m1_rvalid(m1_rvalid_b),
        .m0_rdata(m0_rdata_b), .m1_rdata(m1_rdata_b),
        .mem_addr(mem_addr_b), .mem_data(mem_data_b), .mem_we(mem_we_b), .mem_q(mem_q_b)
    );

    // Synchronous memories: contents start as addr ^ 5A5A, read data after 1 and 3 cycles.
    logic        init_done = 1'b0;
    logic [15:0] mem_a [65536];
    logic [15:0] mem_b [65536];
    logic [15:0] q_b [3];

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 65536; i++) begin
                mem_a[i] <= 16'(i) ^ 16'h5A5A;
                mem_b[i] <= 16'(i) ^ 16'h5A5A;
            end
        end else begin
            if (mem_we_a) mem_a[mem_addr_a] <= mem_data_a;
            if (mem_we_b) mem_b[mem_addr_b] <= mem_data_b;
            mem_q_a <= mem_a[mem_addr_a];
            q_b[0]  <= mem_b[mem_addr_b];
            q_b[1]  <= q_b[0];
            q_b[2]  <= q_b[1];
        end
    end
    assign mem_q_b = q_b[2];

    // Reference model state
    typedef struct {
        int          due;
        logic        port;
        logic [15:0] data;
    } rd_t;

    int          nvec = 0;
    int          nerr = 0;
    int          cyc = 0;
    logic        mlast = 1'b1;
    logic [15:0] shadow [65536];
    rd_t         qa[$];
    rd_t         qb[$];

    logic        e_g0, e_g1, e_we;
    logic [15:0] e_addr, e_data, e_rda, e_rdb;
    logic [1:0]  e_rva, e_rvb;

    task automatic drive(input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                         input logic r1, input logic w1, input logic [15:0] a1, input logic [15:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    // Mid-cycle: derive what the outputs must be right now.
    task automatic settle();
        @(negedge clk);
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            mlast = 1'b1;
        end
        e_g0 = 1'b0;
        e_g1 = 1'b0;
        if (rst_n) begin
            if (m0_req && m1_req) begin
`ifdef MEM_ARB_RR_EN
                if (mlast) e_g0 = 1'b1;
                else       e_g1 = 1'b1;
`else
                e_g0 = 1'b1;
`endif
            end else begin
                e_g0 = m0_req;
                e_g1 = m1_req;
            end
        end
        e_we = 1'b0; e_addr = 16'h0; e_data = 16'h0;
        if (e_g0) begin
            e_we = m0_we; e_addr = m0_addr; e_data = m0_wdata;
        end else if (e_g1) begin
            e_we = m1_we; e_addr = m1_addr; e_data = m1_wdata;
        end
        e_rva = 2'b00; e_rda = 16'h0;
        e_rvb = 2'b00; e_rdb = 16'h0;
        if (qa.size() > 0) begin
            if (qa[0].due == cyc) begin
                e_rva[qa[0].port] = 1'b1;
                e_rda = qa[0].data;
            end
        end
        if (qb.size() > 0) begin
            if (qb[0].due == cyc) begin
                e_rvb[qb[0].port] = 1'b1;
                e_rdb = qb[0].data;
            end
        end
    endtask

    // Clock edge: the expected grant takes effect in the model.
    task automatic commit();
        rd_t r;
        @(posedge clk);
        if (qa.size() > 0) begin
            if (qa[0].due == cyc) void'(qa.pop_front());
        end
        if (qb.size() > 0) begin
            if (qb[0].due == cyc) void'(qb.pop_front());
        end
        if (e_g0 || e_g1) begin
            mlast = e_g1;
            if (e_we) begin
                shadow[e_addr] = e_data;
            end else begin
                r.port = e_g1;
                r.data = shadow[e_addr];
                r.due  = cyc + 1;
                qa.push_back(r);
                r.due  = cyc + 3;
                qb.push_back(r);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
            settle();
            commit();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 0, 16'h0005, 16'h1111, 1, 0, 16'h0006, 16'h2222);
        settle();
        nvec++;
        if ({m0_gnt_a, m1_gnt_a, m0_gnt_b, m1_gnt_b} !== 4'b0) begin
            nerr++; $display("FAIL reset_gnt got %b want 0000", {m0_gnt_a, m1_gnt_a, m0_gnt_b, m1_gnt_b});
        end
        nvec++;
        if ({m0_rvalid_a, m1_rvalid_a, m0_rvalid_b, m1_rvalid_b} !== 4'b0) begin
            nerr++; $display("FAIL reset_rvalid got %b want 0000", {m0_rvalid_a, m1_rvalid_a, m0_rvalid_b, m1_rvalid_b});
        end
        nvec++;
        if ({mem_we_a, mem_addr_a, mem_data_a} !== 33'h0) begin
            nerr++; $display("FAIL reset_mem got we=%b addr=%h data=%h want all 0", mem_we_a, mem_addr_a, mem_data_a);
        end
        commit();
        rst_n = 1'b1;
        settle();
        nvec++;
        if ({m0_gnt_a, m1_gnt_a} !== 2'b10) begin
            nerr++; $display("FAIL first_contention got g0g1=%b want 10", {m0_gnt_a, m1_gnt_a});
        end
        commit();
        idle(4);
    endtask

    task automatic test_single_read();
        drive(1, 0, 16'h0001, 16'h0, 0, 0, 16'h0, 16'h0);
        settle();
        nvec++;
        if ({m0_gnt_a, m1_gnt_a} !== 2'b10) begin
            nerr++; $display("FAIL single_gnt got g0g1=%b want 10", {m0_gnt_a, m1_gnt_a});
        end
        commit();
        drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        settle();
        nvec++;
        if ({m0_rvalid_a, m1_rvalid_a, m0_rdata_a} !== {2'b10, 16'h5A5B}) begin
            nerr++; $display("FAIL single_rd got rv=%b data=%h want rv=10 data=5a5b", {m0_rvalid_a, m1_rvalid_a}, m0_rdata_a);
        end
        commit();
        idle(3);
    endtask

    task automatic test_write_read();
        drive(0, 0, 16'h0, 16'h0, 1, 1, 16'hFFFE, 16'hBEEF);
        settle();
        nvec++;
        if ({m1_gnt_a, mem_we_a, mem_addr_a, mem_data_a} !== {2'b11, 16'hFFFE, 16'hBEEF}) begin
            nerr++; $display("FAIL wr_drive got g1=%b we=%b addr=%h data=%h want 1 1 fffe beef", m1_gnt_a, mem_we_a, mem_addr_a, mem_data_a);
        end
        commit();
        drive(0, 0, 16'h0, 16'h0, 1, 0, 16'hFFFE, 16'h0);
        settle();
        nvec++;
        if ({m1_gnt_a, mem_we_a} !== 2'b10) begin
            nerr++; $display("FAIL rd_gnt got g1=%b we=%b want 1 0", m1_gnt_a, mem_we_a);
        end
        commit();
        drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        settle();
        nvec++;
        if ({m1_rvalid_a, m0_rvalid_a, m1_rdata_a} !== {2'b10, 16'hBEEF}) begin
            nerr++; $display("FAIL raw_data got rv1=%b rv0=%b data=%h want 1 0 beef", m1_rvalid_a, m0_rvalid_a, m1_rdata_a);
        end
        commit();
        idle(3);
    endtask

    task automatic test_contention();
        logic [3:0] seq;
        logic [1:0] eg;
        logic [1:0] pg;
`ifdef MEM_ARB_RR_EN
        seq = 4'b0101;
`else
        seq = 4'b1111;
`endif
        pg = 2'b00;
        for (int i = 0; i < 6; i++) begin
            drive(i < 4, 0, 16'h0020, 16'h0, i < 5, 0, 16'h0021, 16'h0);
            settle();
            eg = (i < 4) ? {~seq[i], seq[i]} : ((i == 4) ? 2'b10 : 2'b00);
            nvec++;
            if ({m1_gnt_a, m0_gnt_a} !== eg) begin
                nerr++; $display("FAIL contention_gnt cyc%0d got g1g0=%b want %b", i, {m1_gnt_a, m0_gnt_a}, eg);
            end
            if (i > 0) begin
                nvec++;
                if ({m1_rvalid_a, m0_rvalid_a} !== pg) begin
                    nerr++; $display("FAIL contention_rv cyc%0d got rv1rv0=%b want %b", i, {m1_rvalid_a, m0_rvalid_a}, pg);
                end
                nvec++;
                if (m0_rdata_a !== (pg[1] ? 16'h5A7B : 16'h5A7A)) begin
                    nerr++; $display("FAIL contention_rd cyc%0d got %h want %h", i, m0_rdata_a, pg[1] ? 16'h5A7B : 16'h5A7A);
                end
            end
            pg = eg;
            commit();
        end
        idle(3);
    endtask

    task automatic test_read_latency3();
        drive(0, 0, 16'h0, 16'h0, 1, 0, 16'h0003, 16'h0);
        settle();
        commit();
        drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        for (int k = 1; k <= 4; k++) begin
            settle();
            nvec++;
            if ({m1_rvalid_b, m0_rvalid_b} !== ((k == 3) ? 2'b10 : 2'b00)) begin
                nerr++; $display("FAIL lat3_rv k=%0d got rv1rv0=%b want %b", k, {m1_rvalid_b, m0_rvalid_b}, (k == 3) ? 2'b10 : 2'b00);
            end
            if (k == 3) begin
                nvec++;
                if (m1_rdata_b !== 16'h5A59) begin
                    nerr++; $display("FAIL lat3_rd got %h want 5a59", m1_rdata_b);
                end
            end
            commit();
        end
    endtask

    task automatic test_reset_mid_read();
        drive(1, 0, 16'h0002, 16'h0, 0, 0, 16'h0, 16'h0);
        settle();
        nvec++;
        if (m0_gnt_b !== 1'b1) begin
            nerr++; $display("FAIL midrst_gnt got %b want 1", m0_gnt_b);
        end
        commit();
        drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        rst_n = 1'b0;
        settle();
        commit();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            nvec++;
            if ({m0_rvalid_b, m1_rvalid_b, m0_rvalid_a, m1_rvalid_a} !== 4'b0) begin
                nerr++; $display("FAIL midrst_rv k=%0d got %b want 0000", k, {m0_rvalid_b, m1_rvalid_b, m0_rvalid_a, m1_rvalid_a});
            end
            commit();
        end
    endtask

    task automatic test_random(input int n);
        logic        act [2];
        logic        we [2];
        logic [15:0] ad [2];
        logic [15:0] dt [2];
        int          wt [2];
        logic [1:0]  og;
        for (int p = 0; p < 2; p++) begin
            act[p] = 1'b0; we[p] = 1'b0; ad[p] = 16'h0; dt[p] = 16'h0; wt[p] = 0;
        end
        for (int i = 0; i < n; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!act[p] && ($urandom_range(0, 99) < 65)) begin
                    act[p] = 1'b1;
                    we[p]  = ($urandom_range(0, 2) == 0);
                    ad[p]  = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'h0010 + 16'($urandom_range(0, 7));
                    dt[p]  = 16'($urandom);
                    wt[p]  = 0;
                end
            end
            drive(act[0], we[0], ad[0], dt[0], act[1], we[1], ad[1], dt[1]);
            settle();
            nvec++;
            if ({m0_gnt_a, m1_gnt_a, m0_gnt_b, m1_gnt_b, mem_we_a, mem_addr_a, mem_data_a} !== {e_g0, e_g1, e_g0, e_g1, e_we, e_addr, e_data}) begin
                nerr++; $display("FAIL rnd_drive cyc%0d got g=%b%b we=%b a=%h d=%h want g=%b%b we=%b a=%h d=%h",
                                 cyc, m0_gnt_a, m1_gnt_a, mem_we_a, mem_addr_a, mem_data_a, e_g0, e_g1, e_we, e_addr, e_data);
            end
            nvec++;
            if ({m1_rvalid_a, m0_rvalid_a, m1_rvalid_b, m0_rvalid_b} !== {e_rva, e_rvb}) begin
                nerr++; $display("FAIL rnd_rvalid cyc%0d got a=%b%b b=%b%b want a=%b b=%b",
                                 cyc, m1_rvalid_a, m0_rvalid_a, m1_rvalid_b, m0_rvalid_b, e_rva, e_rvb);
            end
            if (e_rva != 2'b00) begin
                nvec++;
                if ((e_rva[1] ? m1_rdata_a : m0_rdata_a) !== e_rda) begin
                    nerr++; $display("FAIL rnd_rdata_a cyc%0d got %h want %h", cyc, e_rva[1] ? m1_rdata_a : m0_rdata_a, e_rda);
                end
            end
            if (e_rvb != 2'b00) begin
                nvec++;
                if ((e_rvb[1] ? m1_rdata_b : m0_rdata_b) !== e_rdb) begin
                    nerr++; $display("FAIL rnd_rdata_b cyc%0d got %h want %h", cyc, e_rvb[1] ? m1_rdata_b : m0_rdata_b, e_rdb);
                end
            end
            og = {m1_gnt_a, m0_gnt_a};
            for (int p = 0; p < 2; p++) begin
                if (act[p] && !og[p]) wt[p]++;
`ifdef MEM_ARB_RR_EN
                if (act[p]) begin
                    nvec++;
                    if (wt[p] > 1) begin
                        nerr++; $display("FAIL rnd_starve port%0d waited %0d cycles want at most 1", p, wt[p]);
                    end
                end
`endif
            end
            commit();
            if (e_g0) act[0] = 1'b0;
            if (e_g1) act[1] = 1'b0;
        end
        idle(4);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) shadow[i] = 16'(i) ^ 16'h5A5A;
        drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        @(posedge clk);
        #1;
        init_done = 1'b1;
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_read_latency3();
        test_reset_mid_read();
        test_random(600);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port synchronous `memory` block (16-bit address, 16-bit data, memory-mapped I/O at the top of the address space) between two requesters, typically instruction fetch (port 0) and load/store (port 1). It issues at most one access per cycle to the memory. It tracks in-flight reads with a tag pipeline matched to the memory read latency, and returns read data to the requester that issued the read.

## Interface
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data width.
- `RD_LAT`, 1: memory read latency in cycles. Legal range 1..4.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `m0_req`, `m1_req`  in  1  access request.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  ADDR_W  access address.
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data.
- `m0_gnt`, `m1_gnt`  out  1  request accepted this cycle (combinational).
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid this cycle.
- `m0_rdata`, `m1_rdata`  out  DATA_W  read data.
- `mem_addr`  out  ADDR_W  to `memory.addr`.
- `mem_data`  out  DATA_W  to `memory.data`.
- `mem_we`  out  1  to `memory.we`.
- `mem_q`  in  DATA_W  from `memory.q`.

## Operation
- **Request rule.** A requester raises `req` and holds `we`, `addr` and `wdata` stable until it samples `gnt` = 1 on a rising edge. The access is then complete for writes and issued for reads.
- **Grant rule.**
  - At most one `gnt` is high per cycle.
  - With one requester active, that requester wins.
  - With both active, the priority scheme decides (see Configuration).
  - `gnt` never asserts without the matching `req`.
- **Memory drive.**
  - `mem_addr`, `mem_data` and `mem_we` come from the winner, with `mem_we` = winner `we`.
  - When no requester is granted: `mem_we` = 0, `mem_addr` = 0, `mem_data` = 0.
- **Priority state.** Register `last_gnt` (1 bit) is updated to the winning port on every grant and holds otherwise.
- **Read tracking.**
  - A shift pipeline `RD_LAT` deep; each stage holds `{valid, port}`.
  - Stage 0 is loaded with `{granted && !we, winner}` every cycle.
  - At the last stage, `mN_rvalid` = valid && (port == N).
- **Read data.** `m0_rdata` and `m1_rdata` are both driven from `mem_q` combinationally. Data is meaningful only while the corresponding `rvalid` is high.
- **Ordering.** Reads return in issue order, exactly `RD_LAT` cycles after grant. Reads may be back-to-back, one per cycle, up to `RD_LAT` in flight.
- **Read-after-write** to the same address on consecutive grants returns the new data; the memory write happens at the grant edge.

## Timing
- **Reset values.** `gnt` = 0 whenever `req` = 0. `rvalid` = 0. `mem_we` = 0, `mem_addr` = 0, `mem_data` = 0. `last_gnt` = 1, so port 0 wins the first contention. The tag pipeline is cleared.
- **Grant latency.** 0 cycles: `gnt` is a combinational function of `req` and `last_gnt`.
- **Read latency.** `rvalid` asserts exactly `RD_LAT` cycles after the granting edge and lasts 1 cycle.
- **Simultaneous requests.** The loser keeps `req` high and is granted on the next cycle (round-robin). No other requester can pre-empt it.
- **Reset mid-operation.** In-flight reads are dropped and no `rvalid` appears after `rst_n` deasserts. Writes already granted have completed.
- **Address wrap.** None: `ADDR_W` bits are passed through unchanged, and 'hFFFF (I/O output) is an ordinary write target.

## Configuration
- **`MEM_ARB_RR_EN` defined:** round-robin.
  - On contention, grant the port ≠ `last_gnt`.
  - No starvation: any holding requester is granted within 2 cycles.
- **`MEM_ARB_RR_EN` undefined:** fixed priority.
  - Port 0 always wins contention; port 1 can starve.
  - `last_gnt` is still maintained but unused.

## Structure
- **Shared package `mem_arb_pkg`:** `ADDR_W`/`DATA_W` defaults, the `RD_LAT` maximum (4), typedef `rd_tag_t` {valid, port}, and port index constants `PORT_IF` = 0 and `PORT_LS` = 1.
- **Sub-module `mem_arb_pick`:** a two-input grant picker (req0, req1, last_gnt → gnt0, gnt1) holding the `MEM_ARB_RR_EN` choice.
- **Top level:** muxing, the tag pipeline and `last_gnt` live in the top level.

## Test plan
1. **Reset:** hold `rst_n` = 0 with both `req` = 1 → `gnt` = 0, `rvalid` = 0, `mem_we` = 0, `mem_addr` = 0.
2. **Single read:** port 0 read of addr 'h0001, `RD_LAT` = 1 → `m0_gnt` = 1 that cycle; next cycle `m0_rvalid` = 1 with `m0_rdata` = memory[1]; `m1_rvalid` stays 0.
3. **Write then read:** port 1 writes 'hBEEF to 'hFFFE, then reads 'hFFFE → `m1_rdata` = 'hBEEF one cycle after the read grant.
4. **Contention, `MEM_ARB_RR_EN` defined:** both ports hold reads for 4 cycles → grants alternate 0,1,0,1; `rvalid` alternates in the same order, one cycle later each.
5. **Contention, `MEM_ARB_RR_EN` undefined:** same stimulus → `m0_gnt` = 1 for all 4 cycles; `m1_gnt` = 0 until `m0_req` drops.
6. **Reset mid-read:** `RD_LAT` = 3, grant a read, assert `rst_n` = 0 one cycle later → no `rvalid` ever appears for that read.
